booth_digit_accumulator: RTL and testbench
==========================================

Name: booth_digit_accumulator

Overview:
- Consumer side of the radix-4 Booth recoding interface. Accepts a stream of Booth digits, one per handshake, LSB digit first; each digit is encoded as the one-hot strobes X1/X2/NEG1/NEG2.
- Decodes each digit into a signed partial product of the latched multiplicand, shifts it by 2 bits per digit, and accumulates.
- Emits the full 2W-bit signed product through a valid/ready output.
- Forms the iterative (one digit per cycle) multiplier datapath behind the Booth encoder.

Parameters:
- WIDTH, 16, operand width in bits; must be even and at least 4.
- NDIG, WIDTH/2, Booth digits per product; derived, not overridable.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- start_valid  input  1  multiplicand offered
- start_ready  output  1  block can accept a new operation
- multiplicand  input  WIDTH  signed two's-complement multiplicand
- dig_valid  input  1  Booth digit offered
- dig_ready  output  1  digit can be accepted
- dig_x1  input  1  digit = +1
- dig_x2  input  1  digit = +2
- dig_neg1  input  1  digit = -1
- dig_neg2  input  1  digit = -2 (no strobe asserted means digit = 0)
- dig_last  input  1  marks the final digit of the operation
- prod_valid  output  1  product available
- prod_ready  input  1  downstream accepts product
- product  output  2*WIDTH  signed product
- prod_err  output  1  protocol error during this operation; qualified by prod_valid

Behaviour:
- Clock and reset: one clock. rst_n is synchronous and active-low, sampled on the rising clk edge.
- Reset values: state=IDLE, start_ready=1, dig_ready=0, prod_valid=0, product=0, prod_err=0. The accumulator, digit counter k and latched multiplicand are all cleared.
- Reset mid-operation: any in-flight operation is abandoned without output. The next cycle is IDLE.
- FSM states: IDLE, ACC, DONE. Outputs are registered and decoded from state only: start_ready=(IDLE), dig_ready=(ACC), prod_valid=(DONE).
- IDLE: on start_valid&&start_ready:
  - latch multiplicand into A
  - acc=0, k=0, err=0
  - go to ACC
- ACC, each dig_valid&&dig_ready:
  - Partial product pp = d*A, with d in {0,+1,+2,-1,-2}.
  - pp is sign-extended to 2*WIDTH before any negation or shift, so -2*(-2^(W-1)) does not overflow.
  - acc <= acc + (pp << 2k), computed modulo 2^(2W). k <= k+1.
  - One digit is accepted per cycle at most. Back-to-back digits are accepted with no bubbles.
- Illegal digit (more than one strobe high): the digit is treated as 0, err is set, and processing continues.
- Normal termination: an accepted digit with dig_last=1 and k==NDIG-1 goes to DONE.
- Early last: dig_last=1 with k<NDIG-1 sets err and goes to DONE with the partial acc.
- Missing last: the digit at k==NDIG-1 is accepted without dig_last. This sets err and goes to DONE; no further digits are consumed.
- DONE:
  - product = acc and prod_err = err, both held stable while prod_valid=1 and prod_ready=0.
  - On prod_ready, go to IDLE. There is no IDLE/DONE overlap, so a new start is accepted at the earliest one cycle after the product handshake.
- Latency: a full operation takes 1 start cycle + NDIG digit cycles; prod_valid rises the cycle after the last digit is accepted.
- Inputs are ignored in every state where their ready is low. dig_* arriving in IDLE or DONE is not consumed.

Decomposition:
- Shared package, booth_pkg:
  - digit encoding constants (ZERO/P1/P2/M1/M2)
  - FSM state typedef
  - function booth_digit_value(x1,x2,neg1,neg2), returning a 3-bit signed value and an illegal flag
- Sub-module booth_pp_decode, combinational: inputs A, the strobes and k; outputs the shifted, sign-extended 2W-bit partial product and the illegal flag. The FSM and accumulator stay in the top level.

Test Plan:
- WIDTH=16, A=3, digits (+1,+1,0,0,0,0,0,0 with last on digit 7), sent back-to-back -> product=0x0000000F, prod_err=0, prod_valid rises 9 cycles after start handshake.
- A=-7 (0xFFF9), digits (-2,+2,0 x6) -> product=0xFFFFFFD6 (-42), prod_err=0.
- A=0x8000, digits (0 x7, -2 last) -> product=0x40000000 (2^30), no overflow, prod_err=0.
- Random dig_valid gaps and prod_ready held low 5 cycles -> same products as the back-to-back runs; product/prod_err stable while stalled; dig_ready=0 in DONE.
- Digit with x1&&neg2 high -> counted as 0, prod_err=1. dig_last on digit 2 -> DONE after 3 digits, prod_err=1. Digit 7 without last -> prod_err=1, digit 8 not consumed.
- rst_n low for one cycle after digit 4 -> next cycle start_ready=1, prod_valid=0. A fresh operation with A=3, B-digits of 5 gives 0x0000000F.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth digit consumer: FSM states,
// digit encodings and the strobe-to-digit decode function.
package booth_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ACC  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic signed [2:0] DIG_ZERO = 3'b000;
    localparam logic signed [2:0] DIG_P1   = 3'b001;
    localparam logic signed [2:0] DIG_P2   = 3'b010;
    localparam logic signed [2:0] DIG_M1   = 3'b111;
    localparam logic signed [2:0] DIG_M2   = 3'b110;

    typedef struct packed {
        logic signed [2:0] value;
        logic              illegal;
    } digit_t;

    // More than one strobe high decodes to zero with the illegal flag set.
    function automatic digit_t booth_digit_value(input logic x1, input logic x2,
                                                 input logic neg1, input logic neg2);
        digit_t r;
        r.value   = DIG_ZERO;
        r.illegal = 1'b0;
        case ({x1, x2, neg1, neg2})
            4'b0000: r.value = DIG_ZERO;
            4'b1000: r.value = DIG_P1;
            4'b0100: r.value = DIG_P2;
            4'b0010: r.value = DIG_M1;
            4'b0001: r.value = DIG_M2;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/booth_pp_decode.sv
// Turns one Booth digit into its weighted 2W-bit partial product d*A*4^k.
module booth_pp_decode
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int KW    = 3
) (
    input  logic [WIDTH-1:0]   a,
    input  logic               x1,
    input  logic               x2,
    input  logic               neg1,
    input  logic               neg2,
    input  logic [KW-1:0]      k,
    output logic [2*WIDTH-1:0] pp,
    output logic               illegal
);

    digit_t               dig;
    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   base;

    // Sign-extend before doubling/negating so -2 * most-negative A is exact.
    always_comb begin
        dig   = booth_digit_value(x1, x2, neg1, neg2);
        a_ext = {{WIDTH{a[WIDTH-1]}}, a};
        base  = '0;
        case (dig.value)
            DIG_P1:  base = a_ext;
            DIG_P2:  base = a_ext << 1;
            DIG_M1:  base = -a_ext;
            DIG_M2:  base = -(a_ext << 1);
            default: base = '0;
        endcase
        pp      = base << {k, 1'b0};
        illegal = dig.illegal;
    end

endmodule

// File: rtl/booth_digit_accumulator.sv
// Iterative radix-4 Booth multiplier back end: latches A, accumulates one
// digit per handshake and presents the 2W-bit product.
//   state   | meaning
//   IDLE    | waiting for a multiplicand
//   ACC     | accepting Booth digits, LSB digit first
//   DONE    | product/prod_err held until prod_ready
module booth_digit_accumulator
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               dig_valid,
    output logic               dig_ready,
    input  logic               dig_x1,
    input  logic               dig_x2,
    input  logic               dig_neg1,
    input  logic               dig_neg2,
    input  logic               dig_last,
    output logic               prod_valid,
    input  logic               prod_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               prod_err
);

    localparam int NDIG = WIDTH / 2;
    localparam int KW   = (NDIG > 2) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    state_t               state;
    logic [WIDTH-1:0]     a_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [KW-1:0]        k;
    logic                 err;
    logic [2*WIDTH-1:0]   pp;
    logic                 pp_illegal;
    logic                 k_is_last;

    booth_pp_decode #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_pp_decode (
        .a       (a_reg),
        .x1      (dig_x1),
        .x2      (dig_x2),
        .neg1    (dig_neg1),
        .neg2    (dig_neg2),
        .k       (k),
        .pp      (pp),
        .illegal (pp_illegal)
    );

    assign k_is_last = (k == K_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_reg <= '0;
            acc   <= '0;
            k     <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_reg <= multiplicand;
                        acc   <= '0;
                        k     <= '0;
                        err   <= 1'b0;
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (dig_valid) begin
                        acc <= acc + pp;
                        k   <= k + 1'b1;
                        // A last flag off the final slot, or a final slot without
                        // one, both terminate the operation but flag it.
                        err <= err | pp_illegal | (dig_last ^ k_is_last);
                        if (dig_last || k_is_last) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (prod_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign start_ready = (state == ST_IDLE);
    assign dig_ready   = (state == ST_ACC);
    assign prod_valid  = (state == ST_DONE);
    assign product     = acc;
    assign prod_err    = err;

endmodule

// File: tb/tb_booth_digit_accumulator.sv
// Directed bench for booth_digit_accumulator with a sum-of-weighted-digits model.
module tb_booth_digit_accumulator;

    localparam int WIDTH = 16;
    localparam int NDIG  = 8;
    localparam int ILL   = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] multiplicand;
    logic        dig_valid;
    logic        dig_ready;
    logic        dig_x1, dig_x2, dig_neg1, dig_neg2, dig_last;
    logic        prod_valid;
    logic        prod_ready;
    logic [31:0] product;
    logic        prod_err;

    int          checks = 0;
    int          passes = 0;
    longint      cyc = 0;
    bit          mon_en = 1'b0;
    bit          exp_active = 1'b0;
    logic [31:0] exp_product = '0;
    logic        exp_err = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_digit_accumulator #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .multiplicand (multiplicand),
        .dig_valid    (dig_valid),
        .dig_ready    (dig_ready),
        .dig_x1       (dig_x1),
        .dig_x2       (dig_x2),
        .dig_neg1     (dig_neg1),
        .dig_neg2     (dig_neg2),
        .dig_last     (dig_last),
        .prod_valid   (prod_valid),
        .prod_ready   (prod_ready),
        .product      (product),
        .prod_err     (prod_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    // product = sum d_i * A * 4^i over the digits the block consumes, mod 2^32
    function automatic void model(input logic [15:0] a, input int digs[$], input bit last_on_final,
                                  output logic [31:0] p, output logic e);
        longint sum;
        sum = 0;
        e   = 1'b0;
        for (int i = 0; i < digs.size(); i++) begin
            bit is_last;
            int d;
            is_last = last_on_final && (i == digs.size() - 1);
            d = digs[i];
            if (d == ILL) begin
                e = 1'b1;
                d = 0;
            end
            sum += longint'($signed(a)) * longint'(d) * (longint'(1) <<< (2 * i));
            if (is_last || i == NDIG - 1) begin
                if (!(is_last && i == NDIG - 1)) e = 1'b1;
                break;
            end
        end
        p = sum[31:0];
    endfunction

    task automatic set_strobes(input int d);
        dig_x1   = (d == 1) || (d == ILL);
        dig_x2   = (d == 2);
        dig_neg1 = (d == -1);
        dig_neg2 = (d == -2) || (d == ILL);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (prod_valid) begin
                chk("prod_valid expected", 64'(exp_active), 64'd1);
                chk("product", 64'(product), 64'(exp_product));
                chk("prod_err", 64'(prod_err), 64'(exp_err));
                chk("dig_ready in DONE", 64'(dig_ready), 64'd0);
                chk("start_ready in DONE", 64'(start_ready), 64'd0);
            end else begin
                chk("ready one-hot", 64'(start_ready) + 64'(dig_ready), 64'd1);
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input int digs[$], input bit last_on_final,
                          input bit gaps, input int stall, input bit extra_digit,
                          input int abort_after, input bit use_lit,
                          input logic [31:0] lit_prod, input logic lit_err, input bit chk_lat);
        logic [31:0] mp;
        logic        me;
        longint      t0, t1;
        bit          rdy, got;
        model(a, digs, last_on_final, mp, me);
        if (use_lit) begin
            chk("model product literal", 64'(mp), 64'(lit_prod));
            chk("model err literal", 64'(me), 64'(lit_err));
        end
        exp_product = mp;
        exp_err     = me;
        exp_active  = (abort_after < 0);

        @(negedge clk);
        start_valid  = 1'b1;
        multiplicand = a;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            rdy = start_ready;
            @(posedge clk);
            if (rdy) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) chk("start handshake timeout", 64'd0, 64'd1);
        @(negedge clk);
        start_valid = 1'b0;
        t0 = cyc;

        for (int i = 0; i < digs.size(); i++) begin
            if (gaps) begin
                dig_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            dig_valid = 1'b1;
            set_strobes(digs[i]);
            dig_last = last_on_final && (i == digs.size() - 1);
            got = 1'b0;
            for (int n = 0; n < 50 && !got; n++) begin
                rdy = dig_ready;
                @(posedge clk);
                if (rdy) got = 1'b1;
                else @(negedge clk);
            end
            if (!got) chk("digit handshake timeout", 64'd0, 64'd1);
            @(negedge clk);
            dig_valid = 1'b0;
            if (i == abort_after) begin
                exp_active = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk("start_ready after abort", 64'(start_ready), 64'd1);
                chk("prod_valid after abort", 64'(prod_valid), 64'd0);
                chk("dig_ready after abort", 64'(dig_ready), 64'd0);
                return;
            end
        end
        dig_last = 1'b0;
        set_strobes(0);

        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            if (prod_valid) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) chk("prod_valid timeout", 64'd0, 64'd1);
        t1 = cyc;
        if (chk_lat) chk("latency cycles", 64'(t1 - t0 + 1), 64'(NDIG + 1));

        if (extra_digit) begin
            dig_valid = 1'b1;
            set_strobes(1);
            dig_last = 1'b1;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("prod_valid held", 64'(prod_valid), 64'd1);
        end
        prod_ready = 1'b1;
        @(posedge clk);
        exp_active = 1'b0;
        @(negedge clk);
        prod_ready = 1'b0;
        chk("prod_valid after handshake", 64'(prod_valid), 64'd0);
        chk("start_ready after handshake", 64'(start_ready), 64'd1);
        if (extra_digit) @(negedge clk);
        dig_valid = 1'b0;
        dig_last  = 1'b0;
        set_strobes(0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        rst_n = 1'b0;
        start_valid = 1'b0;
        multiplicand = '0;
        dig_valid = 1'b0;
        dig_last = 1'b0;
        prod_ready = 1'b0;
        set_strobes(0);
        repeat (2) @(negedge clk);
        chk("reset start_ready", 64'(start_ready), 64'd1);
        chk("reset dig_ready", 64'(dig_ready), 64'd0);
        chk("reset prod_valid", 64'(prod_valid), 64'd0);
        chk("reset product", 64'(product), 64'd0);
        chk("reset prod_err", 64'(prod_err), 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // back-to-back runs with latency check
        q = '{1, 1, 0, 0, 0, 0, 0, 0};
        run_op(16'd3, q, 1, 0, 0, 0, -1, 1, 32'h0000000F, 1'b0, 1);
        q = '{-2, 2, 0, 0, 0, 0, 0, 0};
        run_op(16'hFFF9, q, 1, 0, 0, 0, -1, 1, 32'hFFFFFFD6, 1'b0, 1);
        q = '{0, 0, 0, 0, 0, 0, 0, -2};
        run_op(16'h8000, q, 1, 0, 0, 0, -1, 1, 32'h40000000, 1'b0, 1);

        // same operations with digit gaps and a 5-cycle output stall
        q = '{1, 1, 0, 0, 0, 0, 0, 0};
        run_op(16'd3, q, 1, 1, 5, 0, -1, 1, 32'h0000000F, 1'b0, 0);
        q = '{-2, 2, 0, 0, 0, 0, 0, 0};
        run_op(16'hFFF9, q, 1, 1, 5, 0, -1, 1, 32'hFFFFFFD6, 1'b0, 0);
        q = '{0, 0, 0, 0, 0, 0, 0, -2};
        run_op(16'h8000, q, 1, 1, 5, 0, -1, 1, 32'h40000000, 1'b0, 0);

        // protocol errors
        q = '{ILL, 1, 0, 0, 0, 0, 0, 0};
        run_op(16'd5, q, 1, 0, 2, 0, -1, 1, 32'h00000014, 1'b1, 0);
        q = '{1, 1, 1};
        run_op(16'd3, q, 1, 0, 2, 0, -1, 1, 32'h0000003F, 1'b1, 0);
        q = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_op(16'd3, q, 0, 0, 4, 1, -1, 1, 32'h0000FFFF, 1'b1, 0);

        // reset after digit 4, then a fresh A=3 x 5 operation
        q = '{1, 2, -1, 1, 2, 0, 0, 0};
        run_op(16'd7, q, 1, 0, 0, 0, 4, 0, 32'h0, 1'b0, 0);
        q = '{1, 1, 0, 0, 0, 0, 0, 0};
        run_op(16'd3, q, 1, 0, 1, 0, -1, 1, 32'h0000000F, 1'b0, 0);

        // mixed-sign sanity run against the model only
        q = '{2, -1, -2, 1, 0, 2, -1, 1};
        run_op(16'h1234, q, 1, 1, 3, 0, -1, 0, 32'h0, 1'b0, 0);

        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
